dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters.
  - Port 0: core load/store path.
  - Port 1: loader/debug master, which fills and inspects memory.
- Sits between the requesters and the data memory. Drives memory address, write data and the write enable (MemRW).
- Bounded-burst round-robin FSM. Registered read return.

---
 rtl/dmem_arbiter_if.sv | 40 ++++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the data memory and dmem_arbiter.
// slave is the arbiter view; master is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, rvalid0, gnt1, rvalid1,
    output rdata, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, rvalid0, gnt1, rvalid1,
    input  rdata, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Bounded-burst round-robin arbiter for the shared data-memory port.
// DMEM_ARB_PERF_EN adds the conflict_cnt/perf_clr contention counter.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef DMEM_ARB_PERF_EN
  input  logic        perf_clr,
  output logic [15:0] conflict_cnt,
`endif
  dmem_arbiter_if.slave bus
);

  localparam logic [7:0] MB = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t            state;
  logic [7:0]        burst_cnt;
  logic [7:0]        cnt_inc;
  logic              rr;
  logic              g0;
  logic              g1;
  logic              below;
  logic              rd_hit;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] addr_mux;

  assign below   = burst_cnt < MB;
  assign cnt_inc = (burst_cnt == 8'hFF) ? burst_cnt
                                        : burst_cnt + 8'd1;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (bus.req0 && bus.req1) begin
            g0 = rr;
            g1 = !rr;
          end else begin
            g0 = bus.req0;
            g1 = bus.req1;
          end
        end
        OWN0: begin
          if (bus.req0 && (below || !bus.req1)) g0 = 1'b1;
          else g1 = bus.req1;
        end
        OWN1: begin
          if (bus.req1 && (below || !bus.req0)) g1 = 1'b1;
          else g0 = bus.req0;
        end
        default: ;
      endcase
    end
  end

  assign rd_hit = (g0 & ~bus.we0) | (g1 & ~bus.we1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      burst_cnt   <= 8'd0;
      rr          <= 1'b1;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (g0) begin
        rr        <= 1'b0;
        state     <= OWN0;
        burst_cnt <= (state == OWN0) ? cnt_inc : 8'd1;
      end else if (g1) begin
        rr        <= 1'b1;
        state     <= OWN1;
        burst_cnt <= (state == OWN1) ? cnt_inc : 8'd1;
      end else begin
        state     <= IDLE;
        burst_cnt <= 8'd0;
      end
      bus.rvalid0 <= g0 & ~bus.we0;
      bus.rvalid1 <= g1 & ~bus.we1;
      if (rd_hit) rdata_q <= bus.mem_rdata;
    end
  end

  // Idle bus parks on port 0 so the address lines stay quiet.
  assign addr_mux      = g1 ? bus.addr1 : bus.addr0;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = g1 ? bus.wdata1 : bus.wdata0;
  assign bus.mem_we    = (g0 & bus.we0) | (g1 & bus.we1);
  assign bus.gnt0      = g0;
  assign bus.gnt1      = g1;
  assign bus.rdata     = rdata_q;

`ifdef DMEM_ARB_PERF_EN
  logic conflict;

  assign conflict = bus.req0 & bus.req1 & ~(g0 & g1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= 16'd0;
    end else if (perf_clr) begin
      conflict_cnt <= 16'd0;
    end else if (conflict && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a rule-level model.
// Build with DMEM_ARB_PERF_EN to also cover the contention counter.
module tb_dmem_arbiter;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic        perf_clr;
  logic [15:0] conflict_cnt;
  int          exp_cc;
`endif

  dmem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef DMEM_ARB_PERF_EN
    .perf_clr(perf_clr),
    .conflict_cnt(conflict_cnt),
`endif
    .bus(bus)
  );

  logic [31:0] env_mem [64];
  logic [31:0] ref_mem [64];

  assign bus.mem_rdata = env_mem[bus.mem_addr[7:2]];

  int vectors = 0;
  int errs = 0;

  int          had;
  int          run;
  int          last;
  logic        exp_rv0;
  logic        exp_rv1;
  logic [31:0] exp_rdata;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Contention: owner keeps the port until it has used MB grants in a row.
  function automatic int predict(logic r0, logic r1);
    if (r0 && r1) begin
      if (had != 0 && run < MB) return last;
      return 1 - last;
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    had       = 0;
    run       = 0;
    last      = 1;
    exp_rv0   = 1'b0;
    exp_rv1   = 1'b0;
    exp_rdata = 32'h0;
`ifdef DMEM_ARB_PERF_EN
    exp_cc = 0;
`endif
  endtask

  task automatic cycle(output int g);
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] md;
    @(negedge clk);
    g = predict(bus.req0, bus.req1);
    chk1("gnt0", bus.gnt0, g == 0);
    chk1("gnt1", bus.gnt1, g == 1);
    chk1("rvalid0", bus.rvalid0, exp_rv0);
    chk1("rvalid1", bus.rvalid1, exp_rv1);
    chk("rdata", bus.rdata, exp_rdata);
`ifdef DMEM_ARB_PERF_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_cc));
`endif
    w = 1'b0;
    a = bus.addr0;
    d = bus.wdata0;
    if (g == 0) w = bus.we0;
    if (g == 1) begin
      w = bus.we1;
      a = bus.addr1;
      d = bus.wdata1;
    end
    chk1("mem_we", bus.mem_we, w);
    if (g >= 0) begin
      chk("mem_addr", bus.mem_addr, a);
      chk("mem_wdata", bus.mem_wdata, d);
    end
    exp_rv0 = (g == 0) && !bus.we0;
    exp_rv1 = (g == 1) && !bus.we1;
    if (g >= 0 && !w) exp_rdata = ref_mem[a[7:2]];
    if (w) ref_mem[a[7:2]] = d;
    if (g >= 0) begin
      run  = (had != 0 && last == g) ? run + 1 : 1;
      last = g;
      had  = 1;
    end else begin
      had = 0;
      run = 0;
    end
`ifdef DMEM_ARB_PERF_EN
    if (perf_clr) exp_cc = 0;
    else if (bus.req0 && bus.req1 && exp_cc < 65535) exp_cc++;
`endif
    mw = bus.mem_we;
    ma = bus.mem_addr;
    md = bus.mem_wdata;
    @(posedge clk);
    if (mw) env_mem[ma[7:2]] = md;
    #1;
  endtask

  task automatic set0(logic r, logic w, logic [31:0] a, logic [31:0] d);
    bus.req0   = r;
    bus.we0    = w;
    bus.addr0  = a;
    bus.wdata0 = d;
  endtask

  task automatic set1(logic r, logic w, logic [31:0] a, logic [31:0] d);
    bus.req1   = r;
    bus.we1    = w;
    bus.addr1  = a;
    bus.wdata1 = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    set1(1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int          g;
  int          pat [10];
  logic [31:0] wd [8];

  initial begin
    g   = -1;
    pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    rst = 1'b1;
`ifdef DMEM_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    env_mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    model_reset();
    set0(1'b1, 1'b1, 32'h8, 32'h1);
    set1(1'b1, 1'b1, 32'hC, 32'h2);
    #2;
    chk1("rst_gnt0", bus.gnt0, 1'b0);
    chk1("rst_gnt1", bus.gnt1, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk1("rst_rvalid0", bus.rvalid0, 1'b0);
    chk1("rst_rvalid1", bus.rvalid1, 1'b0);
    chk("rst_rdata", bus.rdata, 32'h0);
    do_reset();

    set0(1'b1, 1'b0, 32'h10, 32'h0);
    cycle(g);
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t1_rdata", bus.rdata, 32'hDEADBEEF);
    chk1("t1_rvalid0", bus.rvalid0, 1'b1);
    chk1("t1_rvalid1", bus.rvalid1, 1'b0);
    cycle(g);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      set0(1'b1, 1'b0, {24'h0, 6'($urandom), 2'b0}, 32'h0);
      set1(1'b1, 1'b0, {24'h0, 6'($urandom), 2'b0}, 32'h0);
      cycle(g);
      chk("pattern", 32'(g), 32'(pat[i]));
    end
`ifdef DMEM_ARB_PERF_EN
    chk("conflict10", 32'(conflict_cnt), 32'd10);
    perf_clr = 1'b1;
    cycle(g);
    perf_clr = 1'b0;
    chk("conflict_clr", 32'(conflict_cnt), 32'd0);
    cycle(g);
    chk("conflict_resume", 32'(conflict_cnt), 32'd1);
`endif
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    set1(1'b0, 1'b0, 32'h0, 32'h0);
    cycle(g);

    for (int i = 0; i < 8; i++) begin
      wd[i] = $urandom;
      set1(1'b1, 1'b1, 32'(i * 4), wd[i]);
      cycle(g);
      chk("wr_gnt1", 32'(g), 32'd1);
    end
    set1(1'b0, 1'b0, 32'h0, 32'h0);
    set0(1'b1, 1'b0, 32'h1C, 32'h0);
    cycle(g);
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd_back", bus.rdata, wd[7]);
    cycle(g);

    set0(1'b1, 1'b0, 32'h20, 32'h0);
    set1(1'b1, 1'b0, 32'h24, 32'h0);
    cycle(g);
    chk("tie_rr0", 32'(g), 32'd1);
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    set1(1'b0, 1'b0, 32'h0, 32'h0);
    cycle(g);
    set0(1'b1, 1'b0, 32'h28, 32'h0);
    set1(1'b1, 1'b0, 32'h2C, 32'h0);
    cycle(g);
    chk("tie_rr1", 32'(g), 32'd0);
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    set1(1'b0, 1'b0, 32'h0, 32'h0);
    cycle(g);

    for (int i = 0; i < 3; i++) begin
      set1(1'b1, 1'b1, 32'(32'h40 + i * 4), $urandom);
      cycle(g);
    end
    rst = 1'b1;
    #1;
    chk1("mid_gnt0", bus.gnt0, 1'b0);
    chk1("mid_gnt1", bus.gnt1, 1'b0);
    chk1("mid_mem_we", bus.mem_we, 1'b0);
    chk1("mid_rvalid1", bus.rvalid1, 1'b0);
    chk("mid_rdata", bus.rdata, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    set0(1'b1, 1'b0, 32'h30, 32'h0);
    set1(1'b1, 1'b1, 32'h34, 32'h5);
    cycle(g);
    chk("post_rst", 32'(g), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      if (!bus.req0 || g == 0) begin
        set0($urandom_range(0, 3) != 0, 1'($urandom),
             {24'h0, 6'($urandom), 2'b0}, $urandom);
      end
      if (!bus.req1 || g == 1) begin
        set1($urandom_range(0, 2) != 0, 1'($urandom),
             {24'h0, 6'($urandom), 2'b0}, $urandom);
      end
      if ($urandom_range(0, 31) == 0) bus.req0 = 1'b0;
      if ($urandom_range(0, 31) == 0) bus.req1 = 1'b0;
`ifdef DMEM_ARB_PERF_EN
      perf_clr = $urandom_range(0, 63) == 0;
`endif
      cycle(g);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end
endmodule
